// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and the
// data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: one request at a time, LATENCY cycles of
// wait state, byte-enabled stores, error flag for misaligned/out-of-range.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic        reqFire;
    logic        rspFire;
    logic        doAccess;
    logic        accWe;
    logic        accErr;
    logic [31:0] accAddr;
    logic [31:0] accWdata;
    logic [3:0]  accBe;
    logic [AW-1:0] accIdx;

    assign bus.req_ready = reset && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);

    assign reqFire = bus.req_valid && bus.req_ready;
    assign rspFire = bus.rsp_valid && bus.rsp_ready;

    // With LATENCY=1 the access happens on the acceptance edge, so the live
    // request is used; otherwise the captured copy is.
    assign accWe    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign accAddr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign accWdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign accBe    = (state_q == IDLE) ? bus.req_be    : be_q;
    assign accIdx   = accAddr[AW+1:2];
    assign accErr   = (accAddr[1:0] != 2'b00) || (accAddr[31:2] >= 30'(DEPTH));

    // The access edge is the one on which the wait counter decrements to zero.
    assign doAccess = ((state_q == IDLE) && reqFire && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q <= 4'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (reqFire) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                if (rspFire) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (doAccess) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            err_d   = accErr;
            rdata_d = (!accWe && !accErr) ? mem_q[accIdx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset so committed data survives it.
    always_ff @(posedge clk) begin
        if (reset && doAccess && accWe && !accErr) begin
            for (int b = 0; b < 4; b++) begin
                if (accBe[b]) begin
                    mem_q[accIdx][8*b +: 8] <= accWdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the processor's load/store port.
- Accepts one request at a time over a valid/ready request channel.
- Applies LATENCY cycles of wait state, then returns read data or a write acknowledgement over a valid/ready response channel.
- Supports byte enables and flags misaligned or out-of-range accesses. Used when dmem is replaced by a slower, handshaked memory.

Parameters:
- DEPTH, 64, number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access error.
- busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
  - req_ready=0 while reset is held.
  - Memory array is not reset.
- States:
  - IDLE: req_ready=1. Handshake = req_valid & req_ready on a rising edge. On handshake, capture we/addr/wdata/be, load counter with LATENCY-1, go to WAIT. If LATENCY=1, go straight to RESP and do the access on that edge.
  - WAIT: req_ready=0. Counter decrements each cycle. On the edge where counter==0, perform the access, register the response, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until handshake (rsp_valid & rsp_ready). On handshake go to IDLE; rsp_valid=0 and rsp_rdata/rsp_err clear to 0.
- Timing: request accepted at edge N means rsp_valid is high after edge N+LATENCY. Best-case throughput is one transaction per LATENCY+1 cycles.
- No request pipelining: req_ready=0 in WAIT and RESP. Inputs are ignored there.
- Error when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH:
  - no memory write; rsp_rdata=0; rsp_err=1.
  - Still costs full LATENCY and response handshake.
- Store:
  - Writes only enabled bytes of word req_addr[31:2]; be=0 changes nothing and is not an error.
  - rsp_rdata=0, rsp_err=0.
- Load: rsp_rdata = full word at access edge; req_be is ignored.
- Ordering: a store commits before the next request can be accepted, so a following load returns the stored data.
- Reset mid-transaction (WAIT or RESP): abort to IDLE, no response issued. A store not yet committed is discarded; a committed store remains.
- rsp_ready high while not in RESP is ignored.
- No X on any output after reset deasserts.

Test Plan:
- Reset, then store addr=0x60 data=0x0000_0019 be=1111 -> after 2 cycles rsp_valid=1, err=0, rdata=0. A following load at 0x60 returns 0x0000_0019 exactly 2 cycles after acceptance.
- Partial store: word at 0x64 = 0xAABBCCDD, then store data=0x11223344 be=0101 -> load at 0x64 returns 0xAA22CC44.
- Misaligned load at 0x62, and load at 0x100 (DEPTH=64) -> both give rsp_err=1, rdata=0. Store to 0x100 leaves memory unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable, req_ready=0, and a new req_valid is not accepted.
- Assert reset during WAIT of a store to 0x68 (old value 0x5) -> state returns to IDLE, no rsp_valid, and a load at 0x68 returns 0x5.
- LATENCY=1 build: back-to-back load/store with rsp_ready tied high -> one transaction per 2 cycles, and rsp_valid appears 1 cycle after acceptance.
